// File: rtl/mod_cipher_stream.sv
// Streaming (P + K) mod M encrypt / (C - K) mod M decrypt engine with registered key and output FIFO.
// Latency: 1 cycle from the accepting edge to out_valid. Backpressure: in_ready drops when there is no key, during key_load, or when the FIFO is full.
module mod_cipher_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         not_empty,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok   = push && (count != (AW+1)'(DEPTH));
  assign pop_ok    = pop && (count != '0);
  assign not_empty = (count != '0);
  assign head_dat  = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module mod_cipher_stream #(
  parameter int DATA_W     = 8,
  parameter int MODULUS    = 227,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] key_in,
  input  logic              key_load,
  output logic              key_valid,
  output logic              key_err,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_invalid,
  output logic [7:0]        err_cnt
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [DATA_W:0] MOD_V = (DATA_W+1)'(MODULUS);

  if (DATA_W < 2 || DATA_W > 16) begin : g_bad_width
    $error("mod_cipher_stream: DATA_W must be in 2..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << DATA_W)) begin : g_bad_modulus
    $error("mod_cipher_stream: MODULUS must satisfy 2 <= M <= 2**DATA_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mod_cipher_stream: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic {NO_KEY, RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] key_q;
  logic [AW:0]       count;
  logic              key_ok;
  logic              mode_ok;
  logic              data_ok;
  logic              accept;
  logic              push;
  logic              drop;
  logic [DATA_W:0]   s_sum;
  logic [DATA_W:0]   s_res;

  assign key_ok   = ({1'b0, key_in} < MOD_V);
  assign mode_ok  = (mode == 2'b01) || (mode == 2'b10);
  assign data_ok  = ({1'b0, in_data} < MOD_V);
  assign in_ready = key_valid && !key_load && (count < (AW+1)'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && mode_ok && data_ok;
  assign drop     = accept && !(mode_ok && data_ok);

  // Both branches stay in DATA_W+1 bits; the decrypt wrap adds M before subtracting the key.
  always_comb begin
    s_sum = {1'b0, in_data} + {1'b0, key_q};
    s_res = '0;
    if (mode == 2'b01) begin
      s_res = (s_sum >= MOD_V) ? (s_sum - MOD_V) : s_sum;
    end else if (in_data >= key_q) begin
      s_res = {1'b0, in_data} - {1'b0, key_q};
    end else begin
      s_res = {1'b0, in_data} + MOD_V - {1'b0, key_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= NO_KEY;
      key_valid   <= 1'b0;
      key_q       <= '0;
      key_err     <= 1'b0;
      err_invalid <= 1'b0;
      err_cnt     <= '0;
    end else begin
      key_err     <= key_load && !key_ok;
      err_invalid <= drop;
      if (drop && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (key_load && key_ok) key_q <= key_in;
      case (state)
        NO_KEY: begin
          if (key_load && key_ok) begin
            state     <= RUN;
            key_valid <= 1'b1;
          end
        end
        default: begin
          state     <= RUN;
          key_valid <= 1'b1;
        end
      endcase
    end
  end

  mod_cipher_stream_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_dat  (s_res[DATA_W-1:0]),
    .pop       (out_ready),
    .head_dat  (out_data),
    .not_empty (out_valid),
    .count     (count)
  );
endmodule

// File: tb/tb_mod_cipher_stream.sv
// Bench for mod_cipher_stream: vector table, scoreboard on the output stream, and hand-written corner sequences.
module tb_mod_cipher_stream;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [7:0] key_in;
  logic       key_load;
  logic       key_valid;
  logic       key_err;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err_invalid;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;
  logic [7:0] cur_key = 8'h00;
  int err_model = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  mod_cipher_stream #(.DATA_W(8), .MODULUS(227), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .key_in      (key_in),
    .key_load    (key_load),
    .key_valid   (key_valid),
    .key_err     (key_err),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_invalid (err_invalid),
    .err_cnt     (err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] d, input logic [7:0] k);
    int r;
    if (m == 2'b01) r = (int'(d) + int'(k)) % 227;
    else            r = (int'(d) - int'(k) + 227) % 227;
    return 8'(r);
  endfunction

  function automatic bit beat_ok(input logic [1:0] m, input logic [7:0] d);
    return (m == 2'b01 || m == 2'b10) && (d < 8'd227);
  endfunction

  // Handshakes are stable mid-cycle; decisions here apply to the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        else check("sb_out", 32'(out_data), 32'(sb.pop_front()));
      end
      if (in_valid && in_ready && beat_ok(mode, in_data))
        sb.push_back(model(mode, in_data, cur_key));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check("key_err_pulse", 32'(key_err), 32'(k >= 8'd227));
    if (k < 8'd227) cur_key = k;
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] d);
    mode     = m;
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [1:0] m;
    logic [7:0] d;
    logic [7:0] k;
    logic [7:0] exp;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic acc;
    logic [7:0] nd;

    vecs[0] = '{2'b01, 8'h7A, 8'hC8, 8'h5F, 1'b0};
    vecs[1] = '{2'b10, 8'h5F, 8'hC8, 8'h7A, 1'b0};
    vecs[2] = '{2'b10, 8'h61, 8'h10, 8'h51, 1'b0};
    vecs[3] = '{2'b01, 8'h00, 8'h10, 8'h10, 1'b0};
    vecs[4] = '{2'b01, 8'hE2, 8'h10, 8'h0F, 1'b0};
    vecs[5] = '{2'b10, 8'h00, 8'h10, 8'hD3, 1'b0};
    vecs[6] = '{2'b01, 8'hE3, 8'h10, 8'h00, 1'b1};
    vecs[7] = '{2'b11, 8'h05, 8'h10, 8'h00, 1'b1};
    vecs[8] = '{2'b00, 8'h05, 8'h10, 8'h00, 1'b1};

    rst_n = 1'b0; mode = 2'b01; key_in = 8'h00; key_load = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_key_err", 32'(key_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Illegal key before any legal key: stays in NO_KEY.
    load_key(8'hE3);
    check("badkey_valid", 32'(key_valid), 32'd0);
    check("badkey_ready", 32'(in_ready), 32'd0);
    tick();
    check("key_err_one_cycle", 32'(key_err), 32'd0);

    for (int i = 0; i < 9; i++) begin
      if (!key_valid || cur_key != vecs[i].k) begin
        load_key(vecs[i].k);
        check("key_valid_after_load", 32'(key_valid), 32'd1);
      end
      check("vec_in_ready", 32'(in_ready), 32'd1);
      send(vecs[i].m, vecs[i].d);
      if (vecs[i].exp_err && err_model < 255) err_model++;
      check("vec_out_valid", 32'(out_valid), 32'(!vecs[i].exp_err));
      if (!vecs[i].exp_err) check("vec_out_data", 32'(out_data), 32'(vecs[i].exp));
      check("vec_err_invalid", 32'(err_invalid), 32'(vecs[i].exp_err));
      check("vec_err_cnt", 32'(err_cnt), 32'(err_model));
    end
    tick();

    // Fill the FIFO with the sink stalled, then stream with push and pop together.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b01, 8'(i * 10));
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_head", 32'(out_data), 32'h10);
    out_ready = 1'b1;
    nd = 8'd100;
    mode = 2'b01; in_data = nd; in_valid = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      check("stream_in_ready", 32'(in_ready), 32'(c != 0));
      acc = in_ready;
      tick();
      if (acc) begin
        nd = nd + 8'd1;
        in_data = nd;
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Saturating error counter.
    mode = 2'b11; in_data = 8'h01; in_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (err_model < 255) err_model++;
    end
    in_valid = 1'b0;
    check("sat_err_cnt", 32'(err_cnt), 32'hFF);
    check("sat_err_invalid", 32'(err_invalid), 32'd1);
    tick();
    check("sat_err_pulse_end", 32'(err_invalid), 32'd0);
    check("sat_hold", 32'(err_cnt), 32'hFF);

    // key_load in the same cycle as a beat blocks acceptance.
    key_in = 8'h20; key_load = 1'b1;
    mode = 2'b01; in_data = 8'h01; in_valid = 1'b1;
    #1;
    check("load_blocks_ready", 32'(in_ready), 32'd0);
    tick();
    key_load = 1'b0; in_valid = 1'b0;
    cur_key = 8'h20;
    #1;
    check("load_no_accept", 32'(out_valid), 32'd0);
    check("load_key_valid", 32'(key_valid), 32'd1);

    // Reload with results buffered: buffered entries keep the old key.
    out_ready = 1'b0;
    send(2'b01, 8'h05);
    send(2'b01, 8'h06);
    check("reload_head_before", 32'(out_data), 32'h25);
    load_key(8'h30);
    send(2'b01, 8'h07);
    check("reload_head_after", 32'(out_data), 32'h25);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("reload_drained", 32'(out_valid), 32'd0);
    check("reload_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-stream with three entries buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2'b10, 8'(40 + i));
    check("prerst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_key_valid", 32'(key_valid), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    check("postrst_key_valid", 32'(key_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
